// File: rtl/kalman_pkg.sv
// Shared types, sizes and saturation helpers for the Kalman predict unit.
package kalman_pkg;

  localparam int N_STATE = 6;
  localparam int N_COV   = 36;
  localparam int STATE_W = 32;
  localparam int OUT_W   = 16;

  typedef enum logic [2:0] {
    IDLE,
    STATE,
    COV_A,
    COV_B,
    DONE
  } state_e;

  // Clamp a wide signed value into signed 32-bit range.
  function automatic logic signed [31:0] sat32(input logic signed [63:0] v);
    if (v > 64'sd2147483647) begin
      return 32'sh7fff_ffff;
    end else if (v < -64'sd2147483648) begin
      return 32'sh8000_0000;
    end else begin
      return v[31:0];
    end
  endfunction

  // Clamp a signed 32-bit value into signed 16-bit range.
  function automatic logic signed [15:0] sat16(input logic signed [31:0] v);
    if (v > 32'sd32767) begin
      return 16'sh7fff;
    end else if (v < -32'sd32768) begin
      return 16'sh8000;
    end else begin
      return v[15:0];
    end
  endfunction

endpackage

// File: rtl/kf_scale_add.sv
// Computes a + round(b * dt / 2^FRAC_BITS) + bias, saturated to signed 32 bits.
// The scaled term is dropped when use_b_i is low; bias carries the process-noise addend.
module kf_scale_add
  import kalman_pkg::*;
#(
  parameter int FRAC_BITS = 8
) (
  input  logic signed [31:0] a_i,
  input  logic signed [31:0] b_i,
  input  logic        [15:0] dt_i,
  input  logic               use_b_i,
  input  logic signed [15:0] bias_i,
  output logic signed [31:0] sum_o
);

  localparam logic signed [48:0] Round = 49'sd1 <<< (FRAC_BITS - 1);

  logic signed [48:0] b_ext, dt_ext, prod, scaled;
  logic signed [63:0] a_ext, s_ext, q_ext, total;

  // Fixed-point multiply with round-half-up, then one wide add before clamping.
  always_comb begin
    b_ext  = $signed({{17{b_i[31]}}, b_i});
    dt_ext = $signed({33'd0, dt_i});
    prod   = b_ext * dt_ext;
    scaled = (prod + Round) >>> FRAC_BITS;
    a_ext  = $signed({{32{a_i[31]}}, a_i});
    s_ext  = use_b_i ? $signed({{15{scaled[48]}}, scaled}) : 64'sd0;
    q_ext  = $signed({{48{bias_i[15]}}, bias_i});
    total  = a_ext + s_ext + q_ext;
    sum_o  = sat32(total);
  end

endmodule

// File: rtl/kalman_predict_unit.sv
// Kalman predict step for a 3-D constant-velocity model, one element per clock.
// Phases: STATE (x' = F x), COV_A (A = F P, in place), COV_B (P' = A F^T + Q).
// Define KF_PROC_NOISE_EN to add q_pos/q_vel on the covariance diagonal.
module kalman_predict_unit
  import kalman_pkg::*;
#(
  parameter int FRAC_BITS = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [191:0]  x_in,
  input  logic [1151:0] p_in,
  input  logic [15:0]   dt,
  input  logic [15:0]   q_pos,
  input  logic [15:0]   q_vel,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [95:0]   x_out,
  output logic [575:0]  p_out
);

  localparam logic [5:0] LastState = 6'(N_STATE - 1);
  localparam logic [5:0] LastCov   = 6'(N_COV - 1);

  state_e     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic [2:0] row_q, row_d, col_q, col_d;

  logic signed [STATE_W-1:0] x_q  [N_STATE];
  logic signed [STATE_W-1:0] p_q  [N_COV];
  logic signed [OUT_W-1:0]   xo_q [N_STATE];
  logic signed [OUT_W-1:0]   po_q [N_COV];
  logic        [15:0]        dt_q;

  logic signed [31:0] add_a, add_b, sum;
  logic signed [15:0] bias;
  logic               use_b;
  logic [2:0]         xi;

`ifdef KF_PROC_NOISE_EN
  logic signed [15:0] qpos_q, qvel_q;
`else
  logic unused_q;
  assign unused_q = ^{q_pos, q_vel};
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign xi        = cnt_q[2:0];

  // Sequencer: fixed 6 + 36 + 36 cycle schedule, row/col track the covariance index.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    col_d   = col_q;
    unique case (state_q)
      IDLE: if (in_valid) state_d = STATE;
      STATE: begin
        if (cnt_q == LastState) begin
          cnt_d   = '0;
          state_d = COV_A;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      COV_A, COV_B: begin
        if (cnt_q == LastCov) begin
          cnt_d   = '0;
          row_d   = '0;
          col_d   = '0;
          state_d = (state_q == COV_A) ? COV_B : DONE;
        end else begin
          cnt_d = cnt_q + 6'd1;
          if (col_q == 3'd5) begin
            col_d = '0;
            row_d = row_q + 3'd1;
          end else begin
            col_d = col_q + 3'd1;
          end
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand selection for the single shared scale-add datapath.
  always_comb begin
    add_a = '0;
    add_b = '0;
    use_b = 1'b0;
    bias  = '0;
    unique case (state_q)
      STATE: begin
        add_a = x_q[xi];
        if (xi < 3'd3) begin
          use_b = 1'b1;
          add_b = x_q[xi + 3'd3];
        end
      end
      COV_A: begin
        add_a = p_q[cnt_q];
        if (row_q < 3'd3) begin
          use_b = 1'b1;
          add_b = p_q[cnt_q + 6'd18];
        end
      end
      COV_B: begin
        add_a = p_q[cnt_q];
        if (col_q < 3'd3) begin
          use_b = 1'b1;
          add_b = p_q[cnt_q + 6'd3];
        end
`ifdef KF_PROC_NOISE_EN
        if (row_q == col_q) bias = (row_q < 3'd3) ? qpos_q : qvel_q;
`endif
      end
      default: ;
    endcase
  end

  kf_scale_add #(
    .FRAC_BITS(FRAC_BITS)
  ) u_scale_add (
    .a_i    (add_a),
    .b_i    (add_b),
    .dt_i   (dt_q),
    .use_b_i(use_b),
    .bias_i (bias),
    .sum_o  (sum)
  );

  // FSM and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  // Job capture and per-phase writeback; COV_A overwrites rows 0-2 of P in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dt_q <= '0;
      for (int i = 0; i < N_STATE; i++) begin
        x_q[i]  <= '0;
        xo_q[i] <= '0;
      end
      for (int i = 0; i < N_COV; i++) begin
        p_q[i]  <= '0;
        po_q[i] <= '0;
      end
`ifdef KF_PROC_NOISE_EN
      qpos_q <= '0;
      qvel_q <= '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            dt_q <= dt;
            for (int i = 0; i < N_STATE; i++) x_q[i] <= x_in[32*i +: 32];
            for (int i = 0; i < N_COV; i++) p_q[i] <= p_in[32*i +: 32];
`ifdef KF_PROC_NOISE_EN
            qpos_q <= q_pos;
            qvel_q <= q_vel;
`endif
          end
        end
        STATE:   xo_q[xi] <= sat16(sum);
        COV_A:   p_q[cnt_q] <= sum;
        COV_B:   po_q[cnt_q] <= sat16(sum);
        default: ;
      endcase
    end
  end

  // Flatten output registers onto the packed buses.
  always_comb begin
    x_out = '0;
    p_out = '0;
    for (int i = 0; i < N_STATE; i++) x_out[16*i +: 16] = xo_q[i];
    for (int i = 0; i < N_COV; i++) p_out[16*i +: 16] = po_q[i];
  end

endmodule

// File: doc/kalman_predict_unit.md
KALMAN_PREDICT_UNIT -- requirements
Module: kalman_predict_unit

Interface
REQ-001 SHALL have parameter FRAC_BITS, default 8: fractional bits of dt (Q8.8), q_pos and q_vel.
REQ-002 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1: corrected state/covariance available.
REQ-005 SHALL have port in_ready, output, 1: high only in IDLE.
REQ-006 SHALL have port x_in, input, 192: six signed 32-bit corrected states; element i at bits [32i+31:32i]; 0-2 position, 3-5 velocity.
REQ-007 SHALL have port p_in, input, 1152: 36 signed 32-bit covariance entries, row-major; index 6r+c.
REQ-008 SHALL have port dt, input, 16: unsigned Q8.8 time step, sampled at accept.
REQ-009 SHALL have ports q_pos and q_vel, input, 16 each: signed process-noise diagonals, sampled at accept.
REQ-010 SHALL have port out_valid, output, 1: predicted set valid.
REQ-011 SHALL have port out_ready, input, 1: consumer accepts.
REQ-012 SHALL have port x_out, output, 96: six signed 16-bit predicted states, same packing.
REQ-013 SHALL have port p_out, output, 576: 36 signed 16-bit predicted covariance entries, row-major.

Function
REQ-014 Model: F=[I dt*I; 0 I] (3x3 blocks); x'=F*x; P'=F*P*F^T+Q, Q=diag(q_pos x3, q_vel x3).
REQ-015 Accept on in_valid&&in_ready: register x_in, p_in, dt, q_pos, q_vel; move IDLE->STATE.
REQ-016 STATE, 6 cycles, i=0..5: x'[i]=x[i]+scale(x[i+3]) for i<3, else x[i].
REQ-017 COV_A, 36 cycles, k=0..35 (r=k/6, c=k%6): A[r][c]=P[r][c]+scale(P[r+3][c]) for r<3, else P[r][c].
REQ-018 COV_B, 36 cycles: P'[r][c]=A[r][c]+scale(A[r][c+3]) for c<3, else A[r][c]; q_pos added on r=c<3, q_vel on r=c>=3.
REQ-019 scale(v)=(v*dt + 2^(FRAC_BITS-1)) >>> FRAC_BITS, 48-bit signed product; each sum saturates to signed 32-bit.
REQ-020 Outputs saturate 32->16 bits: >32767 -> 32767, <-32768 -> -32768.
REQ-021 Latency: out_valid rises exactly 78 clocks after the accept edge (DONE); fixed, independent of data.
REQ-022 DONE: x_out/p_out/out_valid held stable while out_ready=0; on out_valid&&out_ready, next state IDLE, out_valid=0, data retained.
REQ-023 in_valid outside IDLE ignored; no queuing.
REQ-024 dt=0: outputs equal saturated inputs plus Q diagonal.

Reset
REQ-025 rst_n low, any state: FSM->IDLE, counters 0, out_valid=0, x_out=0, p_out=0, in_ready=1 from first edge after release.
REQ-026 Reset mid-computation discards the job; no partial output ever asserted.

Configuration
REQ-027 Macro KF_PROC_NOISE_EN defined: Q added per REQ-018.
REQ-028 KF_PROC_NOISE_EN undefined: q_pos/q_vel ports present but ignored; no adder on diagonal; latency unchanged.

Structure
REQ-029 Package kalman_pkg SHALL hold N_STATE=6, N_COV=36, STATE_W=32, OUT_W=16, FSM state type (IDLE, STATE, COV_A, COV_B, DONE), 32- and 16-bit saturate functions.
REQ-030 One sub-module kf_scale_add SHALL implement a+scale(b) with rounding and 32-bit saturation, shared by all three phases.

Verification
REQ-031 Reset held 5 cycles -> out_valid=0, all outputs 0, in_ready=1.
REQ-032 dt=0x0100, x_in=[100,110,120,5,-3,2], p_in[0]=20, p_in[21]=4, others 0, q=0 -> after 78 cycles x_out=[105,107,122,5,-3,2], p_out[0]=24, p_out[3]=4, p_out[18]=4, p_out[21]=4, others 0.
REQ-033 KF_PROC_NOISE_EN defined, dt=0x0080, p_in[0]=20, p_in[21]=8, q_pos=1, q_vel=2 -> p_out[0]=23, p_out[3]=4, p_out[18]=4, p_out[21]=10, p_out[7]=p_out[14]=1, p_out[28]=p_out[35]=2.
REQ-034 dt=0x0100, x_in[0]=32767, x_in[3]=100, x_in[1]=-32768, x_in[4]=-1 -> x_out[0]=32767, x_out[1]=-32768.
REQ-035 out_ready=0 for 10 cycles after out_valid, in_valid pulsed -> outputs stable, in_ready=0, no second job; out_ready=1 -> IDLE next cycle.
REQ-036 rst_n pulsed low at cycle 40 of a job -> out_valid never asserts for it, outputs 0, new job after release completes in 78 cycles.
